bypass_source_pipe: RTL and testbench
=====================================

BYPASS_SOURCE_PIPE -- requirements
Module: bypass_source_pipe

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have inputs ID_Rs1_i, ID_Rs2_i, ID_Rd_i, 5 bits each: source and destination registers of the instruction in ID.
REQ-004 SHALL have inputs ID_RegWrite_i, ID_MemRead_i, 1 bit each: ID-stage control.
REQ-005 SHALL have input Flush_i, 1 bit: branch/jump taken; squash the ID instruction.
REQ-006 SHALL have input EX_ALUResult_i, 32 bits: ALU result of the instruction held in ID/EX.
REQ-007 SHALL have input MEM_ReadData_i, 32 bits: data-memory read data for the instruction held in EX/MEM.
REQ-008 SHALL have outputs ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o, 5 bits each, plus ID_EX_RegWrite_o and ID_EX_MemRead_o, 1 bit each.
REQ-009 SHALL have outputs EX_MEM_Rd_o, 5 bits; EX_MEM_RegWrite_o and EX_MEM_MemRead_o, 1 bit each; EX_MEM_ALUResult_o, 32 bits.
REQ-010 SHALL have outputs MEM_WB_Rd_o, 5 bits; MEM_WB_RegWrite_o, 1 bit; MEM_WB_Data_o, 32 bits (write-back value).
REQ-011 SHALL have output Stall_o, 1 bit: load-use hazard; IF/ID and PC hold this cycle.
REQ-012 SHALL have output StallCount_o, 16 bits: number of cycles with Stall_o high, saturating.

Function
REQ-013 Stall_o SHALL be combinational: 1 iff ID_EX_MemRead_o=1, ID_EX_Rd_o!=0, and ID_EX_Rd_o equals ID_Rs1_i or ID_Rs2_i.
REQ-014 Bubble condition: Stall_o=1 or Flush_i=1.
REQ-015 On each edge without bubble, ID/EX SHALL load ID_Rs1_i, ID_Rs2_i, ID_Rd_i, ID_RegWrite_i and ID_MemRead_i.
REQ-016 On each edge with bubble, ID/EX SHALL load Rd=0, RegWrite=0, MemRead=0, Rs1=0, Rs2=0.
REQ-017 Stall and Flush asserted together SHALL produce a single bubble, identical to either alone.
REQ-018 EX/MEM SHALL load from ID/EX (Rd, RegWrite, MemRead) and from EX_ALUResult_i every edge; it never stalls.
REQ-019 MEM_WB_Data_o SHALL load MEM_ReadData_i when EX_MEM_MemRead_o=1, else EX_MEM_ALUResult_o.
REQ-020 MEM/WB SHALL load Rd and RegWrite from EX/MEM every edge.
REQ-021 Latency: an instruction accepted in ID SHALL appear in ID/EX 1 cycle later, EX/MEM 2 cycles later and MEM/WB 3 cycles later.
REQ-022 Any stage holding Rd=0 SHALL still propagate RegWrite unchanged; suppression of x0 is a consumer responsibility.
REQ-023 A load-use stall SHALL last exactly one cycle per hazard, because the bubble clears ID_EX_MemRead_o.
REQ-024 Back-to-back loads each followed by a dependent use SHALL produce one stall per load.
REQ-025 StallCount_o SHALL increment by 1 on each edge where Stall_o=1 and SHALL hold at 16'hFFFF with no wrap.
REQ-026 Flush_i alone SHALL NOT increment StallCount_o.

Reset
REQ-027 When rst_i=0 at an edge, all ID/EX, EX/MEM and MEM/WB fields SHALL become 0, including data, Rd and control.
REQ-028 When rst_i=0 at an edge, StallCount_o SHALL become 0.
REQ-029 Reset SHALL override stall and flush; while rst_i=0, Stall_o SHALL evaluate to 0 because ID_EX_MemRead_o is 0 after the first reset edge.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight instructions, with no partial write-back emitted afterward.

Verification
REQ-031 Load x5 (ID_MemRead=1, Rd=5), then ID_Rs1=5 -> Stall_o=1 for 1 cycle; ID/EX shows Rd=0/RegWrite=0 next cycle; StallCount_o=1.
REQ-032 Load to x0 followed by a use of x0 -> Stall_o=0, no bubble.
REQ-033 ALU op Rd=7 with ALUResult=32'h1234 -> EX_MEM_ALUResult_o=32'h1234 at cycle +2; MEM_WB_Data_o=32'h1234 and MEM_WB_Rd_o=7 at cycle +3.
REQ-034 Load Rd=9 with MEM_ReadData_i=32'hDEADBEEF in its MEM cycle -> MEM_WB_Data_o=32'hDEADBEEF, MEM_WB_RegWrite_o=1.
REQ-035 Flush_i=1 together with a hazard -> a single bubble; StallCount_o increments by 1 only.
REQ-036 Force 65 540 consecutive hazard cycles, then pulse rst_i low for one edge -> StallCount_o reads 16'hFFFF before reset; all outputs read 0 after reset.

Source files
------------

// File: rtl/bypass_source_pipe.sv
// ID/EX -> EX/MEM -> MEM/WB register chain with load-use stall detection,
// bubble insertion on stall/flush, and a saturating stall-cycle counter.
module bypass_source_pipe (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_Rs1_i,
  input  logic [4:0]  ID_Rs2_i,
  input  logic [4:0]  ID_Rd_i,
  input  logic        ID_RegWrite_i,
  input  logic        ID_MemRead_i,
  input  logic        Flush_i,
  input  logic [31:0] EX_ALUResult_i,
  input  logic [31:0] MEM_ReadData_i,
  output logic [4:0]  ID_EX_Rs1_o,
  output logic [4:0]  ID_EX_Rs2_o,
  output logic [4:0]  ID_EX_Rd_o,
  output logic        ID_EX_RegWrite_o,
  output logic        ID_EX_MemRead_o,
  output logic [4:0]  EX_MEM_Rd_o,
  output logic        EX_MEM_RegWrite_o,
  output logic        EX_MEM_MemRead_o,
  output logic [31:0] EX_MEM_ALUResult_o,
  output logic [4:0]  MEM_WB_Rd_o,
  output logic        MEM_WB_RegWrite_o,
  output logic [31:0] MEM_WB_Data_o,
  output logic        Stall_o,
  output logic [15:0] StallCount_o
);

  logic bubble;

  // A load writing x0 never produces a value worth waiting for.
  assign Stall_o = ID_EX_MemRead_o && (ID_EX_Rd_o != 5'd0) &&
                   ((ID_EX_Rd_o == ID_Rs1_i) || (ID_EX_Rd_o == ID_Rs2_i));
  assign bubble  = Stall_o | Flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ID_EX_Rs1_o        <= '0;
      ID_EX_Rs2_o        <= '0;
      ID_EX_Rd_o         <= '0;
      ID_EX_RegWrite_o   <= 1'b0;
      ID_EX_MemRead_o    <= 1'b0;
      EX_MEM_Rd_o        <= '0;
      EX_MEM_RegWrite_o  <= 1'b0;
      EX_MEM_MemRead_o   <= 1'b0;
      EX_MEM_ALUResult_o <= '0;
      MEM_WB_Rd_o        <= '0;
      MEM_WB_RegWrite_o  <= 1'b0;
      MEM_WB_Data_o      <= '0;
      StallCount_o       <= '0;
    end else begin
      if (bubble) begin
        ID_EX_Rs1_o      <= '0;
        ID_EX_Rs2_o      <= '0;
        ID_EX_Rd_o       <= '0;
        ID_EX_RegWrite_o <= 1'b0;
        ID_EX_MemRead_o  <= 1'b0;
      end else begin
        ID_EX_Rs1_o      <= ID_Rs1_i;
        ID_EX_Rs2_o      <= ID_Rs2_i;
        ID_EX_Rd_o       <= ID_Rd_i;
        ID_EX_RegWrite_o <= ID_RegWrite_i;
        ID_EX_MemRead_o  <= ID_MemRead_i;
      end
      EX_MEM_Rd_o        <= ID_EX_Rd_o;
      EX_MEM_RegWrite_o  <= ID_EX_RegWrite_o;
      EX_MEM_MemRead_o   <= ID_EX_MemRead_o;
      EX_MEM_ALUResult_o <= EX_ALUResult_i;
      MEM_WB_Rd_o        <= EX_MEM_Rd_o;
      MEM_WB_RegWrite_o  <= EX_MEM_RegWrite_o;
      MEM_WB_Data_o      <= EX_MEM_MemRead_o ? MEM_ReadData_i : EX_MEM_ALUResult_o;
      if (Stall_o && (StallCount_o != 16'hFFFF))
        StallCount_o <= StallCount_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_bypass_source_pipe.sv
// Directed bench for bypass_source_pipe: reset, load-use stall, x0 loads,
// ALU/load write-back paths, flush merging, back-to-back loads, saturation.
module tb_bypass_source_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ID_Rs1_i, ID_Rs2_i, ID_Rd_i;
  logic        ID_RegWrite_i, ID_MemRead_i, Flush_i;
  logic [31:0] EX_ALUResult_i, MEM_ReadData_i;
  logic [4:0]  ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o;
  logic        ID_EX_RegWrite_o, ID_EX_MemRead_o;
  logic [4:0]  EX_MEM_Rd_o;
  logic        EX_MEM_RegWrite_o, EX_MEM_MemRead_o;
  logic [31:0] EX_MEM_ALUResult_o;
  logic [4:0]  MEM_WB_Rd_o;
  logic        MEM_WB_RegWrite_o;
  logic [31:0] MEM_WB_Data_o;
  logic        Stall_o;
  logic [15:0] StallCount_o;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  bypass_source_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i), .ID_Rd_i(ID_Rd_i),
    .ID_RegWrite_i(ID_RegWrite_i), .ID_MemRead_i(ID_MemRead_i), .Flush_i(Flush_i),
    .EX_ALUResult_i(EX_ALUResult_i), .MEM_ReadData_i(MEM_ReadData_i),
    .ID_EX_Rs1_o(ID_EX_Rs1_o), .ID_EX_Rs2_o(ID_EX_Rs2_o), .ID_EX_Rd_o(ID_EX_Rd_o),
    .ID_EX_RegWrite_o(ID_EX_RegWrite_o), .ID_EX_MemRead_o(ID_EX_MemRead_o),
    .EX_MEM_Rd_o(EX_MEM_Rd_o), .EX_MEM_RegWrite_o(EX_MEM_RegWrite_o),
    .EX_MEM_MemRead_o(EX_MEM_MemRead_o), .EX_MEM_ALUResult_o(EX_MEM_ALUResult_o),
    .MEM_WB_Rd_o(MEM_WB_Rd_o), .MEM_WB_RegWrite_o(MEM_WB_RegWrite_o),
    .MEM_WB_Data_o(MEM_WB_Data_o), .Stall_o(Stall_o), .StallCount_o(StallCount_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
    ID_Rs1_i = rs1; ID_Rs2_i = rs2; ID_Rd_i = rd;
    ID_RegWrite_i = rw; ID_MemRead_i = mr; Flush_i = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    set_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
    EX_ALUResult_i = 32'hA5A5_0001; MEM_ReadData_i = 32'h5A5A_0002;
    step(); step(); step();
    checks++;
    if ({ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o, ID_EX_RegWrite_o, ID_EX_MemRead_o} !== 17'd0) begin
      failures++; $display("FAIL reset_id_ex: got %h want 0",
        {ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o, ID_EX_RegWrite_o, ID_EX_MemRead_o});
    end
    checks++;
    if ({EX_MEM_Rd_o, EX_MEM_RegWrite_o, EX_MEM_MemRead_o, EX_MEM_ALUResult_o} !== 39'd0) begin
      failures++; $display("FAIL reset_ex_mem: got %h want 0",
        {EX_MEM_Rd_o, EX_MEM_RegWrite_o, EX_MEM_MemRead_o, EX_MEM_ALUResult_o});
    end
    checks++;
    if ({MEM_WB_Rd_o, MEM_WB_RegWrite_o, MEM_WB_Data_o} !== 38'd0) begin
      failures++; $display("FAIL reset_mem_wb: got %h want 0",
        {MEM_WB_Rd_o, MEM_WB_RegWrite_o, MEM_WB_Data_o});
    end
    checks++;
    if (Stall_o !== 1'b0 || StallCount_o !== 16'd0) begin
      failures++; $display("FAIL reset_stall: got stall=%b cnt=%0d want 0/0", Stall_o, StallCount_o);
    end
    rst_i = 1'b1;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    EX_ALUResult_i = '0; MEM_ReadData_i = '0;
    step();
    exp_cnt = 0;
  endtask

  task automatic test_load_use();
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== 1'b1) begin
      failures++; $display("FAIL load_use_stall: got %b want 1", Stall_o);
    end
    step(); exp_cnt++;
    checks++;
    if (ID_EX_Rd_o !== 5'd0 || ID_EX_RegWrite_o !== 1'b0 || ID_EX_MemRead_o !== 1'b0) begin
      failures++; $display("FAIL load_use_bubble: got rd=%0d rw=%b mr=%b want 0/0/0",
        ID_EX_Rd_o, ID_EX_RegWrite_o, ID_EX_MemRead_o);
    end
    checks++;
    if (Stall_o !== 1'b0 || StallCount_o !== 16'd1) begin
      failures++; $display("FAIL load_use_one_cycle: got stall=%b cnt=%0d want 0/1", Stall_o, StallCount_o);
    end
    step();
    checks++;
    if (ID_EX_Rs1_o !== 5'd5 || ID_EX_Rd_o !== 5'd6 || ID_EX_RegWrite_o !== 1'b1) begin
      failures++; $display("FAIL load_use_resume: got rs1=%0d rd=%0d rw=%b want 5/6/1",
        ID_EX_Rs1_o, ID_EX_Rd_o, ID_EX_RegWrite_o);
    end
  endtask

  task automatic test_x0_load();
    set_id(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    checks++;
    if (ID_EX_Rd_o !== 5'd0 || ID_EX_RegWrite_o !== 1'b1 || ID_EX_MemRead_o !== 1'b1) begin
      failures++; $display("FAIL x0_regwrite_kept: got rd=%0d rw=%b mr=%b want 0/1/1",
        ID_EX_Rd_o, ID_EX_RegWrite_o, ID_EX_MemRead_o);
    end
    set_id(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== 1'b0) begin
      failures++; $display("FAIL x0_no_stall: got %b want 0", Stall_o);
    end
    step();
    checks++;
    if (ID_EX_Rd_o !== 5'd3 || StallCount_o !== 16'(exp_cnt)) begin
      failures++; $display("FAIL x0_no_bubble: got rd=%0d cnt=%0d want 3/%0d", ID_EX_Rd_o, StallCount_o, exp_cnt);
    end
  endtask

  task automatic test_alu_path();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    EX_ALUResult_i = 32'h1234;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    EX_ALUResult_i = 32'h0;
    checks++;
    if (EX_MEM_ALUResult_o !== 32'h1234 || EX_MEM_Rd_o !== 5'd7 || EX_MEM_RegWrite_o !== 1'b1) begin
      failures++; $display("FAIL alu_ex_mem: got res=%h rd=%0d rw=%b want 1234/7/1",
        EX_MEM_ALUResult_o, EX_MEM_Rd_o, EX_MEM_RegWrite_o);
    end
    step();
    checks++;
    if (MEM_WB_Data_o !== 32'h1234 || MEM_WB_Rd_o !== 5'd7 || MEM_WB_RegWrite_o !== 1'b1) begin
      failures++; $display("FAIL alu_mem_wb: got data=%h rd=%0d rw=%b want 1234/7/1",
        MEM_WB_Data_o, MEM_WB_Rd_o, MEM_WB_RegWrite_o);
    end
  endtask

  task automatic test_load_path();
    set_id(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    step();
    EX_ALUResult_i = 32'h0000_0040;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    EX_ALUResult_i = 32'h0;
    MEM_ReadData_i = 32'hDEADBEEF;
    checks++;
    if (EX_MEM_MemRead_o !== 1'b1 || EX_MEM_ALUResult_o !== 32'h40) begin
      failures++; $display("FAIL load_ex_mem: got mr=%b addr=%h want 1/40", EX_MEM_MemRead_o, EX_MEM_ALUResult_o);
    end
    step();
    MEM_ReadData_i = 32'h0;
    checks++;
    if (MEM_WB_Data_o !== 32'hDEADBEEF || MEM_WB_RegWrite_o !== 1'b1 || MEM_WB_Rd_o !== 5'd9) begin
      failures++; $display("FAIL load_mem_wb: got data=%h rw=%b rd=%0d want deadbeef/1/9",
        MEM_WB_Data_o, MEM_WB_RegWrite_o, MEM_WB_Rd_o);
    end
  endtask

  task automatic test_flush_hazard();
    set_id(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    step();
    set_id(5'd4, 5'd4, 5'd8, 1'b1, 1'b0, 1'b1);
    checks++;
    if (Stall_o !== 1'b1) begin
      failures++; $display("FAIL flush_hazard_stall: got %b want 1", Stall_o);
    end
    step(); exp_cnt++;
    checks++;
    if ({ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o, ID_EX_RegWrite_o, ID_EX_MemRead_o} !== 17'd0 ||
        StallCount_o !== 16'(exp_cnt)) begin
      failures++; $display("FAIL flush_hazard_bubble: got idex=%h cnt=%0d want 0/%0d",
        {ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o, ID_EX_RegWrite_o, ID_EX_MemRead_o}, StallCount_o, exp_cnt);
    end
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
    checks++;
    if (Stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_only_stall: got %b want 0", Stall_o);
    end
    step();
    checks++;
    if (ID_EX_Rd_o !== 5'd0 || ID_EX_Rs1_o !== 5'd0 || ID_EX_RegWrite_o !== 1'b0 ||
        StallCount_o !== 16'(exp_cnt)) begin
      failures++; $display("FAIL flush_only_bubble: got rd=%0d rs1=%0d rw=%b cnt=%0d want 0/0/0/%0d",
        ID_EX_Rd_o, ID_EX_Rs1_o, ID_EX_RegWrite_o, StallCount_o, exp_cnt);
    end
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    set_id(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0); stalls += int'(Stall_o); step();
    set_id(5'd10, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0); stalls += int'(Stall_o); step();
    set_id(5'd10, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0); stalls += int'(Stall_o); step();
    set_id(5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0); stalls += int'(Stall_o); step();
    set_id(5'd0, 5'd11, 5'd13, 1'b1, 1'b0, 1'b0); stalls += int'(Stall_o); step();
    set_id(5'd0, 5'd11, 5'd13, 1'b1, 1'b0, 1'b0); stalls += int'(Stall_o); step();
    exp_cnt += 2;
    checks++;
    if (stalls !== 2 || StallCount_o !== 16'(exp_cnt)) begin
      failures++; $display("FAIL back_to_back: got stalls=%0d cnt=%0d want 2/%0d", stalls, StallCount_o, exp_cnt);
    end
    checks++;
    if (ID_EX_Rs2_o !== 5'd11 || ID_EX_Rd_o !== 5'd13) begin
      failures++; $display("FAIL back_to_back_resume: got rs2=%0d rd=%0d want 11/13", ID_EX_Rs2_o, ID_EX_Rd_o);
    end
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation_reset();
    for (int i = 0; i < 65540; i++) begin
      set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0); step();
      set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0); step();
    end
    checks++;
    if (StallCount_o !== 16'hFFFF) begin
      failures++; $display("FAIL sat_count: got %h want ffff", StallCount_o);
    end
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    EX_ALUResult_i = 32'hCAFE_0000; MEM_ReadData_i = 32'h1111_2222;
    step();
    set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== 1'b1) begin
      failures++; $display("FAIL sat_hazard_pending: got %b want 1", Stall_o);
    end
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    checks++;
    if ({ID_EX_Rs1_o, ID_EX_Rs2_o, ID_EX_Rd_o, ID_EX_RegWrite_o, ID_EX_MemRead_o,
         EX_MEM_Rd_o, EX_MEM_RegWrite_o, EX_MEM_MemRead_o, EX_MEM_ALUResult_o,
         MEM_WB_Rd_o, MEM_WB_RegWrite_o, MEM_WB_Data_o, Stall_o, StallCount_o} !== '0) begin
      failures++; $display("FAIL midstream_reset: got idex_rd=%0d exmem=%h memwb=%h stall=%b cnt=%h want all 0",
        ID_EX_Rd_o, EX_MEM_ALUResult_o, MEM_WB_Data_o, Stall_o, StallCount_o);
    end
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    EX_ALUResult_i = '0; MEM_ReadData_i = '0;
    step(); step();
    checks++;
    if (MEM_WB_RegWrite_o !== 1'b0 || MEM_WB_Data_o !== 32'd0 || MEM_WB_Rd_o !== 5'd0) begin
      failures++; $display("FAIL reset_no_writeback: got rw=%b data=%h rd=%0d want 0/0/0",
        MEM_WB_RegWrite_o, MEM_WB_Data_o, MEM_WB_Rd_o);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    ID_Rs1_i = '0; ID_Rs2_i = '0; ID_Rd_i = '0;
    ID_RegWrite_i = 1'b0; ID_MemRead_i = 1'b0; Flush_i = 1'b0;
    EX_ALUResult_i = '0; MEM_ReadData_i = '0;
    test_reset();
    test_load_use();
    test_x0_load();
    test_alu_path();
    test_load_path();
    test_flush_hazard();
    test_back_to_back();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
